vga_dtg_out: RTL and testbench

- Display timing generator and pixel output stage for 640x480 at 60 Hz, running from the 100 MHz system clock.
- Sits at the consumer end of the pixel interface:
  - drives pix_row/pix_col to the image generators (road, cars, HUD);
  - samples their 12-bit colour back;
  - emits aligned VGA RGB and sync signals.
- Also supplies a per-frame tick for animation logic.

---
 rtl/vga_pkg.sv | 54 +++++
 rtl/vga_sync_counter.sv | 98 +++++++++
 rtl/vga_dtg_out.sv | 145 ++++++++++++++
 tb/tb_vga_dtg_out.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the 640x480 @ 60 Hz display path.
//   - Timing constants (active area, porches, sync widths, totals) used by the
//     timing generator and by the image generators for screen bounds.
//   - rgb12_t colour type with named 4-bit fields {red, green, blue}.
//   - bar_colour(): colour of one of the eight vertical test-pattern bars.
//   No ports (package).
// ---------------------------------------------------------------------------
package vga_pkg;

  // Horizontal timing, in pixels
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // Vertical timing, in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // System clocks per pixel (100 MHz -> 25 MHz pixel rate)
  localparam int VGA_CLK_DIV = 4;

  // Level driven on hsync/vsync inside the sync window (0 = active low)
  localparam logic VGA_SYNC_POL = 1'b0;

  // Width of the row/column counters (covers 0..799 and 0..524)
  localparam int VGA_CNT_W = 10;

  // 12-bit colour, packed as {R[3:0], G[3:0], B[3:0]}
  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb12_t;

  localparam rgb12_t RGB12_BLACK = '{red: 4'h0, green: 4'h0, blue: 4'h0};

  // Bar k lights each channel fully when the matching bit of k is set:
  // bit 2 -> red, bit 1 -> green, bit 0 -> blue.
  function automatic rgb12_t bar_colour(input logic [2:0] bar);
    rgb12_t c;
    c.red   = {4{bar[2]}};
    c.green = {4{bar[1]}};
    c.blue  = {4{bar[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// ---------------------------------------------------------------------------
// vga_sync_counter
//   Pixel-rate divider plus horizontal/vertical position counters.
//   Ports:
//     clk        in   system clock
//     reset      in   synchronous, active-high
//     pix_en     out  registered strobe, high on the last clk of each pixel
//     h_cnt      out  column counter, 0..H_TOTAL-1
//     v_cnt      out  row counter, 0..V_TOTAL-1
//     video_on   out  counters lie inside the active area (combinational)
//     frame_tick out  one-clk pulse when the h wrap enters the first blank line
// ---------------------------------------------------------------------------
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_TOTAL  = VGA_H_TOTAL,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_TOTAL  = VGA_V_TOTAL,
  parameter int CLK_DIV  = VGA_CLK_DIV
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 pix_en,
  output logic [VGA_CNT_W-1:0] h_cnt,
  output logic [VGA_CNT_W-1:0] v_cnt,
  output logic                 video_on,
  output logic                 frame_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [VGA_CNT_W-1:0] H_LAST   = VGA_CNT_W'(H_TOTAL - 1);
  localparam logic [VGA_CNT_W-1:0] V_LAST   = VGA_CNT_W'(V_TOTAL - 1);
  localparam logic [VGA_CNT_W-1:0] H_ACT_C  = VGA_CNT_W'(H_ACTIVE);
  localparam logic [VGA_CNT_W-1:0] V_ACT_C  = VGA_CNT_W'(V_ACTIVE);
  localparam logic [VGA_CNT_W-1:0] V_TICK   = VGA_CNT_W'(V_ACTIVE - 1);

  logic [DIV_W-1:0]     div_cnt_d, div_cnt_q;
  logic                 pix_en_d, pix_en_q;
  logic [VGA_CNT_W-1:0] h_cnt_d, h_cnt_q;
  logic [VGA_CNT_W-1:0] v_cnt_d, v_cnt_q;
  logic                 frame_tick_d, frame_tick_q;

  always_comb begin
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
    // Decoded from the next divider value so the registered strobe lines up
    // with div_cnt == CLK_DIV-1 and comes straight from a flop.
    pix_en_d = (div_cnt_d == DIV_LAST);

    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    frame_tick_d = 1'b0;
    if (pix_en_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
        // Wrap out of the last visible line: start of vertical blank.
        frame_tick_d = (v_cnt_q == V_TICK);
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Stage boundary: divider and position registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q    <= '0;
      pix_en_q     <= 1'b0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      pix_en_q     <= pix_en_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign pix_en     = pix_en_q;
  assign h_cnt      = h_cnt_q;
  assign v_cnt      = v_cnt_q;
  assign frame_tick = frame_tick_q;
  assign video_on   = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);

endmodule

// File: rtl/vga_dtg_out.sv
// ---------------------------------------------------------------------------
// vga_dtg_out
//   640x480 @ 60 Hz display timing generator and pixel output stage.
//   Presents pix_row/pix_col to the image generators, samples their colour
//   on the last clk of the pixel period and emits RGB together with hsync and
//   vsync, all delayed by exactly one pixel period from the counters.
//   Ports:
//     clk        in   100 MHz system clock
//     reset      in   synchronous, active-high
//     pix_data   in   12-bit colour {R,G,B} for the current pix_row/pix_col
//     test_mode  in   (VGA_TEST_PATTERN_EN only) replace pix_data by 8 bars
//     pix_row    out  vertical counter, 0..524
//     pix_col    out  horizontal counter, 0..799
//     video_on   out  counters inside the active area
//     pix_en     out  one-clk strobe on the last clk of each pixel
//     frame_tick out  one-clk pulse at entry to vertical blank
//     vga_hsync  out  horizontal sync
//     vga_vsync  out  vertical sync
//     vga_red/vga_green/vga_blue  out  4-bit colour channels
//   Build option: define VGA_TEST_PATTERN_EN to add test_mode and the
//   vertical colour-bar generator.
// ---------------------------------------------------------------------------
module vga_dtg_out
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter int   CLK_DIV  = VGA_CLK_DIV,
  parameter logic SYNC_POL = VGA_SYNC_POL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [11:0]          pix_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 test_mode,
`endif
  output logic [VGA_CNT_W-1:0] pix_row,
  output logic [VGA_CNT_W-1:0] pix_col,
  output logic                 video_on,
  output logic                 pix_en,
  output logic                 frame_tick,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic [3:0]           vga_red,
  output logic [3:0]           vga_green,
  output logic [3:0]           vga_blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows are half-open: [START, END)
  localparam logic [VGA_CNT_W-1:0] HS_START = VGA_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [VGA_CNT_W-1:0] HS_END   = VGA_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VGA_CNT_W-1:0] VS_START = VGA_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [VGA_CNT_W-1:0] VS_END   = VGA_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Blanking must yield black even when the upstream colour is unknown, so
  // the active flag selects a constant rather than masking the data.
  function automatic rgb12_t blank_colour(input logic active, input rgb12_t c);
    return active ? c : RGB12_BLACK;
  endfunction

  function automatic logic sync_level(input logic in_window);
    return in_window ? SYNC_POL : ~SYNC_POL;
  endfunction

  logic [VGA_CNT_W-1:0] h_cnt, v_cnt;
  logic                 pix_en_s, video_on_s, frame_tick_s;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL),
    .CLK_DIV  (CLK_DIV)
  ) u_sync_counter (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en_s),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .video_on   (video_on_s),
    .frame_tick (frame_tick_s)
  );

  rgb12_t src_colour;
  rgb12_t rgb_d, rgb_q;
  logic   hsync_d, hsync_q;
  logic   vsync_d, vsync_q;

  always_comb begin
    src_colour = rgb12_t'(pix_data);
`ifdef VGA_TEST_PATTERN_EN
    // Eight 128-pixel-wide bars; only bars 0..4 fall in the visible width.
    if (test_mode) begin
      src_colour = bar_colour(h_cnt[9:7]);
    end
`endif
  end

  // Colour and sync are decoded from the same counter snapshot on the pix_en
  // edge; the image pipeline has had CLK_DIV-1 clks to settle pix_data.
  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_en_s) begin
      rgb_d   = blank_colour(video_on_s, src_colour);
      hsync_d = sync_level((h_cnt >= HS_START) && (h_cnt < HS_END));
      vsync_d = sync_level((v_cnt >= VS_START) && (v_cnt < VS_END));
    end
  end

  // Stage boundary: output registers, one pixel behind the counters
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= RGB12_BLACK;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign pix_row    = v_cnt;
  assign pix_col    = h_cnt;
  assign video_on   = video_on_s;
  assign pix_en     = pix_en_s;
  assign frame_tick = frame_tick_s;
  assign vga_hsync  = hsync_q;
  assign vga_vsync  = vsync_q;
  assign vga_red    = rgb_q.red;
  assign vga_green  = rgb_q.green;
  assign vga_blue   = rgb_q.blue;

endmodule

// File: tb/tb_vga_dtg_out.sv
// ---------------------------------------------------------------------------
// tb_vga_dtg_out
//   Directed bench for vga_dtg_out. u_full runs the 640x480 timing; u_small
//   runs a 16x8-total geometry (8x4 active) so whole frames fit in a short
//   run. Edge indices k count posedges after reset release; outputs are
//   sampled on the following negedge.
// ---------------------------------------------------------------------------
module tb_vga_dtg_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic rst_m, rst_s;
`ifdef VGA_TEST_PATTERN_EN
  logic tm_m, tm_s;
`endif

  logic [9:0]  m_row, m_col, s_row, s_col;
  logic        m_von, m_en, m_tick, m_hs, m_vs;
  logic        s_von, s_en, s_tick, s_hs, s_vs;
  logic [3:0]  m_r, m_g, m_b, s_r, s_g, s_b;
  logic [11:0] m_pd, s_pd, m_rgb, s_rgb;

  // Upstream colour model; full-size pipeline drives X outside the screen.
  assign m_pd  = (m_col >= 10'd640 || m_row >= 10'd480) ? 12'hxxx
               : {m_row[3:0], m_col[3:0], 4'hA};
  assign s_pd  = {s_row[3:0], s_col[3:0], 4'hA};
  assign m_rgb = {m_r, m_g, m_b};
  assign s_rgb = {s_r, s_g, s_b};

  vga_dtg_out u_full (
    .clk        (clk),
    .reset      (rst_m),
    .pix_data   (m_pd),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode  (tm_m),
`endif
    .pix_row    (m_row),
    .pix_col    (m_col),
    .video_on   (m_von),
    .pix_en     (m_en),
    .frame_tick (m_tick),
    .vga_hsync  (m_hs),
    .vga_vsync  (m_vs),
    .vga_red    (m_r),
    .vga_green  (m_g),
    .vga_blue   (m_b)
  );

  vga_dtg_out #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .CLK_DIV  (4), .SYNC_POL (1'b0)
  ) u_small (
    .clk        (clk),
    .reset      (rst_s),
    .pix_data   (s_pd),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode  (tm_s),
`endif
    .pix_row    (s_row),
    .pix_col    (s_col),
    .video_on   (s_von),
    .pix_en     (s_en),
    .frame_tick (s_tick),
    .vga_hsync  (s_hs),
    .vga_vsync  (s_vs),
    .vga_red    (s_r),
    .vga_green  (s_g),
    .vga_blue   (s_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int   hf1, hr1, hf2, hf_post;
  int   s_vf, s_vr, s_t1, s_t2, s_tcount;
  int   m_vs_low, m_ticks;
  logic prev_mh, prev_sv;

  initial begin
    hf1 = -1; hr1 = -1; hf2 = -1; hf_post = -1;
    s_vf = -1; s_vr = -1; s_t1 = -1; s_t2 = -1; s_tcount = 0;
    m_vs_low = 0; m_ticks = 0;
    rst_m = 1'b1;
    rst_s = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    tm_m = 1'b0;
    tm_s = 1'b0;
`endif
    repeat (5) @(negedge clk);

    // Reset state
    chk("rst_row",   32'(m_row), 32'd0);
    chk("rst_col",   32'(m_col), 32'd0);
    chk("rst_rgb",   32'(m_rgb), 32'h000);
    chk("rst_hsync", 32'(m_hs), 32'd1);
    chk("rst_vsync", 32'(m_vs), 32'd1);
    chk("rst_pixen", 32'(m_en), 32'd0);
    chk("rst_tick",  32'(m_tick), 32'd0);
    chk("rst_von",   32'(m_von), 32'd1);

    rst_m = 1'b0;
    rst_s = 1'b0;
    prev_mh = m_hs;
    prev_sv = s_vs;

    for (int k = 1; k <= 10800; k++) begin
      @(negedge clk);
      if (k <= 12) begin
        chk("m_pix_en_seq", 32'(m_en), 32'((k % 4) == 3));
        chk("s_pix_en_seq", 32'(s_en), 32'((k % 4) == 3));
      end
      if (k == 4) begin
        chk("col_after_4", 32'(m_col), 32'd1);
        chk("rgb_px_0_0", 32'(m_rgb), 32'h00A);
      end
      // hsync edges on the full-size instance
      if (prev_mh && !m_hs) begin
        if (hf1 < 0) hf1 = k;
        else if (hf2 < 0) hf2 = k;
      end
      if (!prev_mh && m_hs && hr1 < 0) hr1 = k;
      prev_mh = m_hs;
      if (!m_vs) m_vs_low++;
      if (m_tick) m_ticks++;
      if (k == 2804) begin
        chk("blank_col700_rgb", 32'(m_rgb), 32'h000);
        chk("blank_col701_von", 32'(m_von), 32'd0);
      end
      if (k == 3200) begin
        chk("line1_row", 32'(m_row), 32'd1);
        chk("line1_col", 32'(m_col), 32'd0);
      end
      if (k == 9624) chk("rgb_px_5_3", 32'(m_rgb), 32'h35A);

      // Small-geometry instance: frame-level timing
      if (s_tick) begin
        if (k <= 1400) s_tcount++;
        if (s_t1 < 0) begin
          s_t1 = k;
          chk("s_tick_row", 32'(s_row), 32'd4);
          chk("s_tick_col", 32'(s_col), 32'd0);
        end else if (s_t2 < 0) begin
          s_t2 = k;
        end
      end
      if (prev_sv && !s_vs && s_vf < 0) s_vf = k;
      if (!prev_sv && s_vs && s_vf >= 0 && s_vr < 0) s_vr = k;
      prev_sv = s_vs;
      if (k == 76) begin
        chk("s_rgb_px_2_1", 32'(s_rgb), 32'h12A);
        chk("s_von_active", 32'(s_von), 32'd1);
      end
      if (k == 396) begin
        chk("s_blank_row6", 32'(s_rgb), 32'h000);
        chk("s_von_blank", 32'(s_von), 32'd0);
      end
    end

    chk("hsync_fall1", 32'(hf1), 32'd2628);
    chk("hsync_low_len", 32'(hr1 - hf1), 32'd384);
    chk("line_period", 32'(hf2 - hf1), 32'd3200);
    chk("m_vsync_stays_high", 32'(m_vs_low), 32'd0);
    chk("s_tick_first", 32'(s_t1), 32'd256);
    chk("s_tick_period", 32'(s_t2 - s_t1), 32'd512);
    chk("s_tick_count", 32'(s_tcount), 32'd3);
    chk("s_vsync_fall", 32'(s_vf), 32'd324);
    chk("s_vsync_low_len", 32'(s_vr - s_vf), 32'd128);

    // Mid-frame reset at (row 3, col 300)
    chk("pre_rst_row", 32'(m_row), 32'd3);
    chk("pre_rst_col", 32'(m_col), 32'd300);
    rst_m = 1'b1;
    @(negedge clk);
    chk("mid_rst_row",   32'(m_row), 32'd0);
    chk("mid_rst_col",   32'(m_col), 32'd0);
    chk("mid_rst_hsync", 32'(m_hs), 32'd1);
    chk("mid_rst_vsync", 32'(m_vs), 32'd1);
    chk("mid_rst_rgb",   32'(m_rgb), 32'h000);
    chk("mid_rst_tick",  32'(m_tick), 32'd0);
    rst_m = 1'b0;
    prev_mh = m_hs;
    for (int k = 1; k <= 2700; k++) begin
      @(negedge clk);
      if (k == 4) chk("post_rst_col", 32'(m_col), 32'd1);
      if (prev_mh && !m_hs && hf_post < 0) hf_post = k;
      prev_mh = m_hs;
      if (m_tick) m_ticks++;
    end
    chk("post_rst_hsync_fall", 32'(hf_post), 32'd2628);
    chk("hsync_low_col675", 32'(m_hs), 32'd0);

    // Reset while hsync is in its window must return it inactive
    rst_m = 1'b1;
    @(negedge clk);
    chk("rst_in_sync_hsync", 32'(m_hs), 32'd1);
    if (m_tick) m_ticks++;
    rst_m = 1'b0;
    chk("m_no_frame_tick", 32'(m_ticks), 32'd0);

`ifdef VGA_TEST_PATTERN_EN
    rst_m = 1'b1;
    tm_m  = 1'b1;
    @(negedge clk);
    rst_m = 1'b0;
    for (int k = 1; k <= 2052; k++) begin
      @(negedge clk);
      if (k == 4)    chk("bar0_col0",   32'(m_rgb), 32'h000);
      if (k == 520)  chk("bar1_col129", 32'(m_rgb), 32'h00F);
      if (k == 2052) chk("bar4_col512", 32'(m_rgb), 32'hF00);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
